// File: rtl/dsp_frame_sequencer_if.sv
// dsp_frame_sequencer_if: frame control, instruction memory and core issue signals of the sequencer
interface dsp_frame_sequencer_if #(
  parameter int INSTR_ADDR_WIDTH  = 10,
  parameter int SAMPLE_ADDR_WIDTH = 10,
  parameter int PARAM_ADDR_WIDTH  = 10,
  parameter int INSTR_WIDTH       = 6 + SAMPLE_ADDR_WIDTH + PARAM_ADDR_WIDTH
);
  logic                         sample_tick;
  logic [INSTR_ADDR_WIDTH-1:0]  prog_last;
  logic [INSTR_ADDR_WIDTH-1:0]  instr_rd_addr;
  logic [INSTR_WIDTH-1:0]       instr_rd_data;
  logic [INSTR_WIDTH-1:0]       instr_out;
  logic [SAMPLE_ADDR_WIDTH-1:0] rot_base;
  logic                         busy;
  logic                         frame_done;
  logic                         overrun;
  logic                         overrun_clr;
  modport master (
    input  sample_tick, prog_last, instr_rd_data, overrun_clr,
    output instr_rd_addr, instr_out, rot_base, busy, frame_done, overrun
  );
  modport slave (
    output sample_tick, prog_last, instr_rd_data, overrun_clr,
    input  instr_rd_addr, instr_out, rot_base, busy, frame_done, overrun
  );
endinterface

// File: rtl/dsp_frame_sequencer.sv
// dsp_frame_sequencer: per-frame program pass issue with circular-buffer sample address rotation
module dsp_frame_sequencer #(
  parameter int INSTR_ADDR_WIDTH  = 10,
  parameter int SAMPLE_ADDR_WIDTH = 10,
  parameter int PARAM_ADDR_WIDTH  = 10,
  parameter int INSTR_WIDTH       = 6 + SAMPLE_ADDR_WIDTH + PARAM_ADDR_WIDTH,
  parameter int PIPE_DEPTH        = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  dsp_frame_sequencer_if.master  bus
);
  localparam int CW = $clog2(PIPE_DEPTH + 2);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t                       state_q;
  logic [INSTR_ADDR_WIDTH-1:0]  pc_q, last_q;
  logic [SAMPLE_ADDR_WIDTH-1:0] rot_q;
  logic [CW-1:0]                cnt_q;
  logic                         fetch_v_q, busy_q, done_q, ovr_q;
  logic [INSTR_WIDTH-1:0]       out_q, out_d;
  logic [5:0]                   op;
  logic [SAMPLE_ADDR_WIDTH-1:0] sa;
  logic [PARAM_ADDR_WIDTH-1:0]  pa;
  assign {op, sa, pa} = bus.instr_rd_data;
  // sum is self-determined inside the concatenation, giving the modulo wrap
  assign out_d = (op == '0) ? '0 : {op, sa + rot_q, pa};
  assign bus.instr_rd_addr = pc_q;
  assign bus.instr_out     = out_q;
  assign bus.rot_base      = rot_q;
  assign bus.busy          = busy_q;
  assign bus.frame_done    = done_q;
  assign bus.overrun       = ovr_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      last_q    <= '0;
      rot_q     <= '0;
      cnt_q     <= '0;
      fetch_v_q <= 1'b0;
      out_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      fetch_v_q <= state_q == RUN;
      out_q     <= fetch_v_q ? out_d : '0;
      done_q    <= state_q == DRAIN && cnt_q == '0;
      ovr_q     <= (bus.sample_tick && state_q != IDLE) || (ovr_q && !bus.overrun_clr);
      case (state_q)
        IDLE: if (bus.sample_tick) begin
          last_q  <= bus.prog_last;
          pc_q    <= '0;
          rot_q   <= rot_q + '1;
          busy_q  <= 1'b1;
          state_q <= RUN;
        end
        // PC parks on the last address so it can never wrap mid-pass
        RUN: if (pc_q == last_q) begin
          cnt_q   <= CW'(PIPE_DEPTH + 1);
          state_q <= DRAIN;
        end else pc_q <= pc_q + INSTR_ADDR_WIDTH'(1);
        DRAIN: if (cnt_q == '0) begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end else cnt_q <= cnt_q - CW'(1);
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dsp_frame_sequencer.sv
// tb_dsp_frame_sequencer: directed frame passes checked cycle by cycle against hand-derived timing
module tb_dsp_frame_sequencer;
  logic clk = 1'b0;
  logic reset_n;
  int n_chk = 0;
  int n_pass = 0;
  int n_done;
  logic [25:0] mem [1024];
  logic [25:0] first_out;
  dsp_frame_sequencer_if bus();
  dsp_frame_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) bus.instr_rd_data <= mem[bus.instr_rd_addr];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  function automatic logic [25:0] model_out(input logic [25:0] w, input logic [9:0] r);
    logic [9:0] s;
    s = w[19:10] + r;
    return (w[25:20] == 6'd0) ? 26'd0 : {w[25:20], s, w[9:0]};
  endfunction
  task automatic frame(input int last, input logic [9:0] rot, input int ovr_k,
                       input bit clr_too, input bit start, input int chain_last);
    int n;
    n = last + 8;
    if (start) begin
      bus.prog_last = 10'(last);
      bus.sample_tick = 1'b1;
      step();
      bus.sample_tick = 1'b0;
    end
    for (int k = 1; k <= n; k++) begin
      chk("busy", 32'(bus.busy), 32'(k <= last + 7));
      if (k <= last + 1) chk("rd_addr", 32'(bus.instr_rd_addr), 32'(k - 1));
      chk("instr_out", 32'(bus.instr_out), (k >= 3 && k <= last + 3) ? 32'(model_out(mem[k-3], rot)) : 32'd0);
      chk("frame_done", 32'(bus.frame_done), 32'(k == n));
      chk("rot_base", 32'(bus.rot_base), 32'(rot));
      if (ovr_k != 0) chk("overrun", 32'(bus.overrun), 32'(k > ovr_k));
      if (k == 3) first_out = bus.instr_out;
      if (k == ovr_k) begin
        bus.sample_tick = 1'b1;
        bus.overrun_clr = clr_too;
      end
      if (k == n && chain_last >= 0) begin
        bus.prog_last = 10'(chain_last);
        bus.sample_tick = 1'b1;
      end
      step();
      bus.sample_tick = 1'b0;
      bus.overrun_clr = 1'b0;
    end
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0]    = {6'h01, 10'h005, 10'h033};
    mem[1]    = {6'h02, 10'h010, 10'h044};
    mem[2]    = {6'h00, 10'h123, 10'h155};
    mem[3]    = {6'h3F, 10'h3FF, 10'h3FF};
    mem[1023] = {6'h05, 10'h200, 10'h001};
    reset_n = 1'b0;
    bus.sample_tick = 1'b0;
    bus.overrun_clr = 1'b0;
    bus.prog_last = '0;
    step();
    step();
    chk("rst_instr_out", 32'(bus.instr_out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    chk("rst_rd_addr", 32'(bus.instr_rd_addr), 32'd0);
    reset_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (bus.frame_done || bus.busy || bus.instr_out != 0 || bus.rot_base != 0) n_done++;
    end
    chk("idle_quiet", 32'(n_done), 32'd0);
    // basic pass with an overrunning tick at the 5th cycle after the frame tick
    frame(3, 10'h3FF, 5, 1'b0, 1'b1, -1);
    chk("rot1_sample", 32'(first_out[19:10]), 32'h004);
    chk("rot1_param", 32'(first_out[9:0]), 32'h033);
    chk("ovr_sticky", 32'(bus.overrun), 32'd1);
    bus.overrun_clr = 1'b1;
    step();
    bus.overrun_clr = 1'b0;
    chk("ovr_cleared", 32'(bus.overrun), 32'd0);
    // tick on the frame_done cycle chains into a single-instruction pass
    frame(3, 10'h3FE, 0, 1'b0, 1'b1, 0);
    chk("rot2_sample", 32'(first_out[19:10]), 32'h003);
    frame(0, 10'h3FD, 0, 1'b0, 1'b0, -1);
    chk("rot3_sample", 32'(first_out[19:10]), 32'h002);
    chk("rot3_param", 32'(first_out[9:0]), 32'h033);
    chk("chain_no_ovr", 32'(bus.overrun), 32'd0);
    frame(1, 10'h3FC, 2, 1'b1, 1'b1, -1);
    chk("ovr_set_wins", 32'(bus.overrun), 32'd1);
    bus.overrun_clr = 1'b1;
    step();
    bus.overrun_clr = 1'b0;
    chk("ovr_cleared2", 32'(bus.overrun), 32'd0);
    // asynchronous reset in the middle of a pass
    bus.prog_last = 10'd3;
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    step();
    step();
    chk("pre_rst_out", 32'(bus.instr_out), 32'(model_out(mem[0], 10'h3FB)));
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_instr_out", 32'(bus.instr_out), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_rot", 32'(bus.rot_base), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    frame(1, 10'h3FF, 0, 1'b0, 1'b1, -1);
    // full-size program ends on the compare, PC parks at the top address
    frame(1023, 10'h3FE, 0, 1'b0, 1'b1, -1);
    chk("max_rd_hold", 32'(bus.instr_rd_addr), 32'd1023);
    chk("max_idle_busy", 32'(bus.busy), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
